ir_nec_transmit: RTL
====================

Name: ir_nec_transmit

Overview:
- NEC-format infrared frame transmitter, 50 MHz clock domain; the transmit-side counterpart of the IR_RECEIVE decoder.
- Accepts a 32-bit word and sends leader, 32 data bits (LSB first), stop mark and inter-frame gap. Also sends the short NEC repeat frame on request.
- Drives two outputs: oIRDA, an active-low demodulated-level output for loopback into IR_RECEIVE, and oIR_LED, a 38 kHz carrier-modulated LED drive.

Parameters:
- LEADER_MARK, 450000, leader mark length in cycles (9.0 ms)
- LEADER_SPACE, 225000, leader space length in cycles (4.5 ms)
- REPEAT_SPACE, 112500, repeat-frame space length in cycles (2.25 ms)
- BIT_MARK, 28000, mark length per bit and for the stop mark (0.56 ms)
- ZERO_SPACE, 28000, space length for a 0 bit (0.56 ms)
- ONE_SPACE, 84500, space length for a 1 bit (1.69 ms)
- GAP_LEN, 2000000, minimum idle time after the stop mark (40 ms)
- CARRIER_HALF, 658, carrier half-period in cycles (about 38 kHz)

Ports:
- iCLK  input  1  clock, 50 MHz
- iRST_n  input  1  asynchronous active-low reset
- iSTART  input  1  request to send a data frame; sampled only in IDLE
- iREPEAT  input  1  request to send a repeat frame; sampled only in IDLE
- iDATA  input  32  frame word; bit 0 is sent first; latched on the accept cycle
- oIRDA  output  1  demodulated line level; 0 during mark, 1 otherwise
- oIR_LED  output  1  carrier output; toggles during mark, 0 otherwise
- oBUSY  output  1  high from the cycle after accept until the return to IDLE
- oDONE  output  1  one-cycle pulse when GAP completes

Behaviour:
- Reset is iRST_n, asynchronous, active-low; clock is iCLK.
- Reset values: state=IDLE, oIRDA=1, oIR_LED=0, oBUSY=0, oDONE=0, all counters 0, shift register 0.
- Reset mid-frame aborts immediately. Outputs return to their reset values with no oDONE.
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- All outputs are registered. Phase counter (21 bits) clears on every state entry. A phase of length N ends when count == N-1, so each phase lasts exactly N cycles.
- IDLE:
  - iSTART=1: latch iDATA, clear bit index (6 bits), clear the repeat flag, go to LEAD_MARK next cycle.
  - else iREPEAT=1: set the repeat flag, go to LEAD_MARK.
  - iSTART and iREPEAT together: data frame wins.
- LEAD_MARK: lasts LEADER_MARK cycles, then LEAD_SPACE.
- LEAD_SPACE: lasts REPEAT_SPACE cycles if the repeat flag is set, else LEADER_SPACE cycles.
  - Repeat flag set: go to STOP_MARK.
  - Otherwise: go to BIT_MARK.
- BIT_MARK: lasts BIT_MARK cycles, then BIT_SPACE.
- BIT_SPACE: lasts ONE_SPACE cycles if shift[0]=1, else ZERO_SPACE cycles.
  - At the end: shift right by 1 and increment the bit index.
  - Index was 31: go to STOP_MARK. Otherwise go to BIT_MARK.
- STOP_MARK: lasts BIT_MARK cycles, then GAP.
- GAP: lasts GAP_LEN cycles, then IDLE with oDONE=1 for that single cycle.
- oIRDA: 0 in LEAD_MARK, BIT_MARK and STOP_MARK; 1 in every other state.
- oIR_LED:
  - A carrier counter clears at each mark entry, so every mark starts with oIR_LED=1.
  - oIR_LED toggles every CARRIER_HALF cycles while in a mark.
  - Forced to 0 in every non-mark state.
- oBUSY: 1 in every state except IDLE.
- Back-to-back requests: oBUSY falls in the same cycle oDONE pulses. A new iSTART is accepted in that IDLE cycle.
- iSTART/iREPEAT while busy: ignored, no queuing. iDATA changes after accept have no effect.
- Frame word convention: iDATA[31:24] = ~iDATA[23:16] (inverted command over command). The block transmits the word as given and does not check this.

Test Plan:
- Data frame iDATA=32'hE11E00FF:
  - oIRDA low exactly 450000 cycles, then high 225000.
  - Bit 0 mark 28000 cycles, space 84500.
  - Bit 8 space 28000.
  - Stop mark ends 3399000 cycles after frame start.
  - oDONE pulses 2000000 cycles after the stop mark ends.
- Loopback of oIRDA into IR_RECEIVE with iDATA=32'hE11E00FF: receiver oDATA=32'hE11E00FF with one oDATA_READY pulse.
- Carrier, measured during the leader:
  - oIR_LED toggles every 658 cycles, with 342 rising edges.
  - oIR_LED is 0 throughout every space and the gap.
- Repeat, iREPEAT=1:
  - oIRDA low 450000, high 112500, low 28000, then high.
  - oDONE after 2000000 more cycles; no data bits.
- Busy and priority:
  - iSTART pulse mid-frame with a different iDATA: ignored, first frame unchanged.
  - iSTART=iREPEAT=1 in IDLE: full data frame sent.
- Reset at bit 10: oIRDA=1 and oIR_LED=0 immediately. oBUSY=0, no oDONE. Next iSTART produces a full clean frame.

Source files
------------

// File: rtl/ir_nec_transmit.sv
// NEC infrared frame transmitter: leader, 32 data bits LSB first, stop mark and gap,
// or the short repeat frame. Drives a demodulated line level and a carrier-modulated LED.
module ir_nec_transmit #(
    parameter int LEADER_MARK  = 450000,
    parameter int LEADER_SPACE = 225000,
    parameter int REPEAT_SPACE = 112500,
    parameter int BIT_MARK     = 28000,
    parameter int ZERO_SPACE   = 28000,
    parameter int ONE_SPACE    = 84500,
    parameter int GAP_LEN      = 2000000,
    parameter int CARRIER_HALF = 658
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iSTART,
    input  logic        iREPEAT,
    input  logic [31:0] iDATA,
    output logic        oIRDA,
    output logic        oIR_LED,
    output logic        oBUSY,
    output logic        oDONE
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEAD_MARK, ST_LEAD_SPACE, ST_BIT_MARK, ST_BIT_SPACE, ST_STOP_MARK, ST_GAP
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [20:0] cnt;
    logic [20:0] len;
    logic [15:0] car_cnt;
    logic [5:0]  bit_idx;
    logic [31:0] shift;
    logic        rpt;
    logic        phase_end;
    logic        advance;

    function automatic logic is_mark(input state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

    always_comb begin
        len = 21'd1;
        case (state)
            ST_LEAD_MARK:  len = 21'(LEADER_MARK);
            ST_LEAD_SPACE: len = rpt ? 21'(REPEAT_SPACE) : 21'(LEADER_SPACE);
            ST_BIT_MARK:   len = 21'(BIT_MARK);
            ST_BIT_SPACE:  len = shift[0] ? 21'(ONE_SPACE) : 21'(ZERO_SPACE);
            ST_STOP_MARK:  len = 21'(BIT_MARK);
            ST_GAP:        len = 21'(GAP_LEN);
            default:       len = 21'd1;
        endcase
    end

    assign phase_end = (cnt == len - 21'd1);

    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:       nxt = (iSTART || iREPEAT) ? ST_LEAD_MARK : ST_IDLE;
            ST_LEAD_MARK:  nxt = ST_LEAD_SPACE;
            ST_LEAD_SPACE: nxt = rpt ? ST_STOP_MARK : ST_BIT_MARK;
            ST_BIT_MARK:   nxt = ST_BIT_SPACE;
            ST_BIT_SPACE:  nxt = (bit_idx == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
            ST_STOP_MARK:  nxt = ST_GAP;
            ST_GAP:        nxt = ST_IDLE;
            default:       nxt = ST_IDLE;
        endcase
    end

    assign advance = (state == ST_IDLE) ? (iSTART || iREPEAT) : phase_end;

    // Outputs are set on the edge that enters a state, so they track the state exactly.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            car_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rpt     <= 1'b0;
            oIRDA   <= 1'b1;
            oIR_LED <= 1'b0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            if (advance) begin
                state   <= nxt;
                cnt     <= '0;
                car_cnt <= '0;
                oIRDA   <= !is_mark(nxt);
                oIR_LED <= is_mark(nxt);
                oBUSY   <= (nxt != ST_IDLE);
                oDONE   <= (nxt == ST_IDLE);
                if (state == ST_IDLE) begin
                    if (iSTART) begin
                        shift   <= iDATA;
                        bit_idx <= '0;
                        rpt     <= 1'b0;
                    end else begin
                        rpt <= 1'b1;
                    end
                end
                if (state == ST_BIT_SPACE) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 6'd1;
                end
            end else if (state != ST_IDLE) begin
                cnt <= cnt + 21'd1;
                if (is_mark(state)) begin
                    if (car_cnt == 16'(CARRIER_HALF - 1)) begin
                        car_cnt <= '0;
                        oIR_LED <= ~oIR_LED;
                    end else begin
                        car_cnt <= car_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule
